// File: rtl/agg_arbiter.sv
// agg_arbiter: round-robin arbiter that hands one requester FIFO at a time to a
// wide-word aggregator for a burst of FETCH_WIDTH beats.
// Optional feature macro: AGG_ARB_HIPRI_EN (requester 0 gets high priority).
// The default build (macro undefined) is a pure round-robin arbiter.
module agg_arbiter #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_empty_n,
  output logic [NUM_REQ-1:0]            req_deq,
  output logic [DATA_WIDTH-1:0]         agg_data,
  output logic                          agg_empty_n,
  input  logic                          agg_deq,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy,
  output logic                          burst_done
);

  localparam int unsigned BEAT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int unsigned SUM_W  = ID_WIDTH + 1;
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(FETCH_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                state_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [ID_WIDTH-1:0]   grant_id_q;
  logic [BEAT_W-1:0]     beat_q;
  logic                  burst_done_q;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic [ID_WIDTH-1:0]   cand;
  logic                  beat;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

`ifdef AGG_ARB_HIPRI_EN
  logic                  last_zero_q;
  logic                  pool_any;
  logic [ID_WIDTH-1:0]   pool_win;
`endif

  // (base + off) mod NUM_REQ, valid for non-power-of-two NUM_REQ
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int unsigned         off);
    logic [SUM_W-1:0] s;
    s = SUM_W'(base) + SUM_W'(off);
    if (s >= SUM_W'(NUM_REQ)) s = s - SUM_W'(NUM_REQ);
    return ID_WIDTH'(s);
  endfunction

  // Split the flat request data bus into per-requester words
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef AGG_ARB_HIPRI_EN
  // Requester 0 alternates with the round-robin pool of requesters 1..N-1,
  // so it wins whenever it did not hold the previous grant (or nobody else asks)
  always_comb begin
    cand     = rr_ptr_q;
    pool_win = rr_ptr_q;
    pool_any = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      cand = wrap_add(rr_ptr_q, unsigned'(i));
      if (req_empty_n[cand] && (cand != '0)) begin
        pool_win = cand;
        pool_any = 1'b1;
      end
    end
    if (req_empty_n[0] && !(last_zero_q && pool_any)) begin
      winner = '0;
    end else begin
      winner = pool_win;
    end
  end
`else
  // First requesting index at or above rr_ptr, wrapping to 0
  always_comb begin
    cand   = rr_ptr_q;
    winner = rr_ptr_q;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      cand = wrap_add(rr_ptr_q, unsigned'(i));
      if (req_empty_n[cand]) winner = cand;
    end
  end
`endif

  // Pointer that follows the current owner
  assign next_ptr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_WIDTH'(1);

  // A beat is an accepted word from the owner during a burst
  assign beat = (state_q == BURST) && agg_deq && agg_empty_n;

  // Arbitration / burst FSM with beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      beat_q       <= '0;
      burst_done_q <= 1'b0;
`ifdef AGG_ARB_HIPRI_EN
      last_zero_q  <= 1'b0;
`endif
    end else begin
      burst_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_empty_n) begin
            grant_id_q  <= winner;
            beat_q      <= '0;
            state_q     <= BURST;
`ifdef AGG_ARB_HIPRI_EN
            last_zero_q <= (winner == '0);
`endif
          end
        end
        BURST: begin
          if (beat) begin
            if (beat_q == LAST_BEAT) begin
              state_q      <= IDLE;
              burst_done_q <= 1'b1;
`ifdef AGG_ARB_HIPRI_EN
              if (grant_id_q != '0) rr_ptr_q <= next_ptr;
`else
              rr_ptr_q     <= next_ptr;
`endif
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Steer the owner's FIFO through to the aggregator while bursting
  always_comb begin
    agg_data    = '0;
    agg_empty_n = 1'b0;
    req_deq     = '0;
    if (state_q == BURST) begin
      agg_data             = words[grant_id_q];
      agg_empty_n          = req_empty_n[grant_id_q];
      req_deq[grant_id_q]  = agg_deq & req_empty_n[grant_id_q];
    end
  end

  assign busy       = (state_q == BURST);
  assign grant_id   = grant_id_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_agg_arbiter.sv
// Testbench for agg_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_agg_arbiter;

  localparam int DW = 16;
  localparam int FW = 4;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_empty_n;
  logic [NR-1:0]    req_deq;
  logic [DW-1:0]    agg_data;
  logic             agg_empty_n;
  logic             agg_deq;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic             burst_done;

  always #5 clk = ~clk;

  agg_arbiter #(
    .DATA_WIDTH (DW),
    .FETCH_WIDTH(FW),
    .NUM_REQ    (NR),
    .ID_WIDTH   (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_data   (req_data),
    .req_empty_n(req_empty_n),
    .req_deq    (req_deq),
    .agg_data   (agg_data),
    .agg_empty_n(agg_empty_n),
    .agg_deq    (agg_deq),
    .grant_id   (grant_id),
    .busy       (busy),
    .burst_done (burst_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 when idle), beats taken, rotation pointer
  int m_owner = -1;
  int m_grant = 0;
  int m_beats = 0;
  int m_rr    = 0;
  int m_done  = 0;
  int m_last0 = 0;
  bit m_known = 1'b0;

  // FIFO read pointers: each requester presents word {id, count}
  int seq [NR];

  // Logs of observed DUT behaviour
  int       grants[$];
  int       beats_log[$];
  int       deq_cnt [NR];
  int       done_cnt;
  int       starve_cnt;
  bit       prev_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] en);
    int j;
`ifdef AGG_ARB_HIPRI_EN
    if (en[0] && m_last0 == 0) return 0;
    for (int k = 0; k < NR; k++) begin
      j = (m_rr + k) % NR;
      if (j != 0 && en[j]) return j;
    end
    return 0;
`else
    for (int k = 0; k < NR; k++) begin
      j = (m_rr + k) % NR;
      if (en[j]) return j;
    end
    return 0;
`endif
  endfunction

  task automatic clear_logs();
    grants.delete();
    beats_log.delete();
    for (int i = 0; i < NR; i++) deq_cnt[i] = 0;
    done_cnt   = 0;
    starve_cnt = 0;
    prev_busy  = 1'b0;
  endtask

  // One clock cycle: drive, compare against model, log, advance model
  task automatic cycle(input logic r, input logic [NR-1:0] en, input logic dq);
    logic [NR-1:0] exp_deq;
    logic [DW-1:0] exp_data;
    logic          exp_ae;
    @(negedge clk);
    rst         = r;
    req_empty_n = en;
    agg_deq     = dq;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {4'(i), 12'(seq[i])};
    #1;
    exp_deq  = '0;
    exp_data = '0;
    exp_ae   = 1'b0;
    if (m_owner >= 0) begin
      exp_data = {4'(m_owner), 12'(seq[m_owner])};
      exp_ae   = en[m_owner];
      if (dq && en[m_owner]) exp_deq[m_owner] = 1'b1;
    end
    if (m_known) begin
      check("busy",        64'(busy),        64'(m_owner >= 0));
      check("grant_id",    64'(grant_id),    64'(m_grant));
      check("burst_done",  64'(burst_done),  64'(m_done));
      check("agg_empty_n", 64'(agg_empty_n), 64'(exp_ae));
      check("agg_data",    64'(agg_data),    64'(exp_data));
      check("req_deq",     64'(req_deq),     64'(exp_deq));
    end
    if (busy && !prev_busy) grants.push_back(int'(grant_id));
    prev_busy = busy;
    if (busy && agg_deq && agg_empty_n) beats_log.push_back(int'(agg_data));
    if (busy && !agg_empty_n) starve_cnt++;
    for (int i = 0; i < NR; i++) deq_cnt[i] += int'(req_deq[i]);
    if (burst_done) done_cnt++;
    for (int i = 0; i < NR; i++) if (exp_deq[i]) seq[i]++;
    if (r) begin
      m_owner = -1; m_grant = 0; m_beats = 0; m_rr = 0; m_done = 0; m_last0 = 0;
      m_known = 1'b1;
    end else begin
      m_done = 0;
      if (m_owner < 0) begin
        if (|en) begin
          m_grant = pick(en);
          m_owner = m_grant;
          m_beats = 0;
          m_last0 = (m_grant == 0) ? 1 : 0;
        end
      end else if (exp_deq != '0) begin
        m_beats++;
        if (m_beats == FW) begin
`ifdef AGG_ARB_HIPRI_EN
          if (m_owner != 0) m_rr = (m_owner + 1) % NR;
`else
          m_rr = (m_owner + 1) % NR;
`endif
          m_owner = -1;
          m_done  = 1;
        end
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) seq[i] = 0;
    cycle(1'b1, '0, 1'b0);
    clear_logs();
  endtask

  function automatic int gat(input int k);
    return (k < grants.size()) ? grants[k] : 99;
  endfunction

  function automatic int bat(input int k);
    return (k < beats_log.size()) ? beats_log[k] : -1;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order [4];
    rst = 1'b1; req_empty_n = '0; agg_deq = 1'b0; req_data = '0;
    for (int i = 0; i < NR; i++) seq[i] = 0;
    clear_logs();

    // Reset state
    do_reset();
    cycle(1'b0, '0, 1'b0);
    check("rst_busy",  64'(busy),       64'(0));
    check("rst_grant", 64'(grant_id),   64'(0));
    check("rst_done",  64'(burst_done), 64'(0));
    check("rst_deq",   64'(req_deq),    64'(0));

    // Requesters 0 and 2 always ready, sink always ready
    do_reset();
    for (int c = 0; c < 21; c++) cycle(1'b0, 4'b0101, 1'b1);
    check("a_ngrant", 64'(grants.size()), 64'(4));
    check("a_g0", 64'(gat(0)), 64'(0));
    check("a_g1", 64'(gat(1)), 64'(2));
    check("a_g2", 64'(gat(2)), 64'(0));
    check("a_g3", 64'(gat(3)), 64'(2));
    check("a_deq0", 64'(deq_cnt[0]), 64'(8));
    check("a_deq2", 64'(deq_cnt[2]), 64'(8));
    check("a_deq13", 64'(deq_cnt[1] + deq_cnt[3]), 64'(0));
    check("a_done", 64'(done_cnt), 64'(4));

    // Only requester 3 ready
    do_reset();
    cycle(1'b0, 4'b1000, 1'b1);
    check("b_idle", 64'(busy), 64'(0));
    for (int c = 0; c < 5; c++) cycle(1'b0, 4'b1000, 1'b1);
    check("b_grant", 64'(gat(0)), 64'(3));
    check("b_nbeat", 64'(beats_log.size()), 64'(4));
    for (int k = 0; k < 4; k++) check("b_word", 64'(bat(k)), 64'(16'h3000 + k));
    check("b_done", 64'(done_cnt), 64'(1));

    // Owner runs dry mid-burst while requester 1 waits
    do_reset();
    for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0011, 1'b1);
    for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0010, 1'b1);
    for (int c = 0; c < 2; c++) cycle(1'b0, 4'b0011, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);
    check("c_grant",  64'(gat(0)), 64'(0));
    check("c_ngrant", 64'(grants.size()), 64'(1));
    check("c_starve", 64'(starve_cnt), 64'(3));
    check("c_deq1",   64'(deq_cnt[1]), 64'(0));
    check("c_deq0",   64'(deq_cnt[0]), 64'(4));
    check("c_done",   64'(done_cnt), 64'(1));

    // Sink pulls while owner is empty
    do_reset();
    cycle(1'b0, 4'b0100, 1'b0);
    for (int c = 0; c < 5; c++) cycle(1'b0, 4'b0000, 1'b1);
    check("d_busy", 64'(busy), 64'(1));
    check("d_deq",  64'(deq_cnt[0] + deq_cnt[1] + deq_cnt[2] + deq_cnt[3]), 64'(0));
    for (int c = 0; c < 4; c++) cycle(1'b0, 4'b0100, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0);
    check("d_nbeat", 64'(beats_log.size()), 64'(4));
    check("d_deq2",  64'(deq_cnt[2]), 64'(4));
    check("d_done",  64'(done_cnt), 64'(1));

    // Reset in the middle of a burst by requester 1
    do_reset();
    for (int c = 0; c < 3; c++) cycle(1'b0, 4'b0010, 1'b1);
    check("e_grant1", 64'(gat(0)), 64'(1));
    cycle(1'b1, 4'b1111, 1'b1);
    clear_logs();
    cycle(1'b0, 4'b1111, 1'b1);
    check("e_busy",  64'(busy), 64'(0));
    check("e_gid",   64'(grant_id), 64'(0));
    check("e_deq",   64'(req_deq), 64'(0));
    cycle(1'b0, 4'b1111, 1'b1);
    check("e_regrant", 64'(gat(0)), 64'(0));
    check("e_deq1",    64'(deq_cnt[1]), 64'(0));

    // Everyone requesting: grant order
    do_reset();
    for (int c = 0; c < 20; c++) cycle(1'b0, 4'b1111, 1'b1);
`ifdef AGG_ARB_HIPRI_EN
    exp_order = '{0, 1, 0, 2};
`else
    exp_order = '{0, 1, 2, 3};
`endif
    check("f_ngrant", 64'(grants.size()), 64'(4));
    for (int k = 0; k < 4; k++) check("f_order", 64'(gat(k)), 64'(exp_order[k]));

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [NR-1:0] en;
      for (int i = 0; i < NR; i++) en[i] = ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 199) == 0), en, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
